// File: rtl/diff_manch_dec.sv
// Differential Manchester decoder: recovers half-bit phase from the mid-bit
// transitions, then delivers decoded bits and MSB-first WIDTH-bit words once locked.
module diff_manch_dec #(
  parameter int WIDTH     = 8,
  parameter int LOCK_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             locked,
  output logic             err
);

  localparam int CW = $clog2(LOCK_BITS + 1);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic {
    BND = 1'b0,
    MID = 1'b1
  } phase_t;

  phase_t ph, ph_next;

  logic             s1, s, sp;
  logic             t;
  logic             good, viol;
  logic             cand;
  logic [CW-1:0]    good_cnt;
  logic [BW-1:0]    bcnt;
  logic [WIDTH-2:0] sh;

  // din is asynchronous: two flops before anything looks at it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s  <= 1'b0;
      sp <= 1'b0;
    end else begin
      s1 <= din;
      s  <= s1;
      sp <= s;
    end
  end

  assign t = s ^ sp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ph <= BND;
    else      ph <= ph_next;
  end

  // A missing mid-bit transition means this slot was really a boundary,
  // so the next slot is treated as the mid-bit slot.
  always_comb begin
    ph_next = MID;
    good    = 1'b0;
    viol    = 1'b0;
    if (ph == MID) begin
      if (t) begin
        ph_next = BND;
        good    = 1'b1;
      end else begin
        ph_next = MID;
        viol    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand       <= 1'b0;
      good_cnt   <= '0;
      bcnt       <= '0;
      sh         <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      bit_valid  <= 1'b0;
      word_valid <= 1'b0;
      err        <= 1'b0;
      if (ph == BND) begin
        cand <= ~t;
      end else if (good) begin
        if (good_cnt != CW'(LOCK_BITS)) good_cnt <= good_cnt + 1'b1;
        if (locked) begin
          bit_out   <= cand;
          bit_valid <= 1'b1;
          sh        <= (WIDTH-1)'({sh, cand});
          if (bcnt == BW'(WIDTH - 1)) begin
            word_out   <= {sh, cand};
            word_valid <= 1'b1;
            bcnt       <= '0;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end else if (good_cnt == CW'(LOCK_BITS - 1)) begin
          // the bit that completes acquisition is consumed, not delivered
          locked <= 1'b1;
        end
      end else if (viol) begin
        cand     <= 1'b1;
        good_cnt <= '0;
        locked   <= 1'b0;
        err      <= locked;
        bcnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_diff_manch_dec.sv
// Bench for diff_manch_dec: encoder tasks drive the line, a model derived from the
// line-code rules predicts each delivered bit/word and its cycle.
module tb_diff_manch_dec;
  localparam int WIDTH     = 8;
  localparam int LOCK_BITS = 4;

  typedef struct {
    logic [WIDTH-1:0] pattern;
    logic             invert;
    int               nbytes;
    logic [WIDTH-1:0] exp_word;
    int               exp_words;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             bit_out, bit_valid, word_valid, locked, err;
  logic [WIDTH-1:0] word_out;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // reference model state
  logic             exp_q[$];
  int               exp_cyc_q[$];
  logic [WIDTH-1:0] exp_wq[$];
  int               exp_wcyc_q[$];
  logic             track = 1'b0;
  int               n_sent;
  logic [WIDTH-1:0] acc;
  int               acc_n;
  int               lock_cyc   = -100;
  int               lat_e0     = -100;
  int               first_wcyc = -1;
  int               data_start = -1;
  logic             line = 1'b0;
  logic             inv  = 1'b0;

  // observed activity
  int               err_cnt  = 0;
  int               fall_cnt = 0;
  logic             got_b[$];
  logic [WIDTH-1:0] got_w[$];
  logic             prev_locked = 1'b0;
  logic             prev_bv     = 1'b0;

  diff_manch_dec #(.WIDTH(WIDTH), .LOCK_BITS(LOCK_BITS)) dut (
    .clk(clk), .rst(rst), .din(din),
    .bit_out(bit_out), .bit_valid(bit_valid),
    .word_out(word_out), .word_valid(word_valid),
    .locked(locked), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic reset_and_idle(input logic inv_in, input int idle);
    @(negedge clk);
    rst = 1'b0;
    din = inv_in;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  task automatic arm(input logic inv_in, input logic trk);
    exp_q.delete(); exp_cyc_q.delete(); exp_wq.delete(); exp_wcyc_q.delete();
    got_b.delete(); got_w.delete();
    n_sent = 0; acc = '0; acc_n = 0;
    lock_cyc = -100; first_wcyc = -1; data_start = -1;
    err_cnt = 0; fall_cnt = 0;
    inv = inv_in; line = 1'b0; track = trk;
  endtask

  // The first LOCK_BITS bits of an aligned stream are consumed by acquisition;
  // every later bit appears 3 cycles after its boundary slot is sampled.
  task automatic model_bit(input logic b, input int e);
    if (n_sent == LOCK_BITS - 1) lock_cyc = e + 3;
    if (n_sent >= LOCK_BITS) begin
      exp_q.push_back(b);
      exp_cyc_q.push_back(e + 3);
      acc = {acc[WIDTH-2:0], b};
      acc_n++;
      if (acc_n == WIDTH) begin
        exp_wq.push_back(acc);
        exp_wcyc_q.push_back(e + 3);
        acc_n = 0;
      end
    end
    n_sent++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, output int e);
    if (!b) line = ~line;
    @(negedge clk);
    din = line ^ inv;
    e = cyc + 1;
    if (data_start < 0) data_start = e;
    line = ~line;
    @(negedge clk);
    din = line ^ inv;
    if (track) model_bit(b, e);
  endtask

  task automatic send_byte(input logic [WIDTH-1:0] v);
    int e;
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(v[i], e);
  endtask

  task automatic send_preamble();
    int e;
    for (int i = 0; i < LOCK_BITS; i++) send_bit(1'b1, e);
  endtask

  task automatic end_stream();
    repeat (4) @(negedge clk);
    if (track) begin
      check("drain_bits", exp_q.size(), 0);
      check("drain_words", exp_wq.size(), 0);
      check("stream_err_count", err_cnt, 0);
    end
    track = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (err) begin
      err_cnt++;
      check("err_drops_lock", locked, 1'b0);
      check("err_without_bit", bit_valid, 1'b0);
    end
    if (prev_locked && !locked) fall_cnt++;
    if (prev_bv && bit_valid) check("bit_valid_back_to_back", 1'b1, 1'b0);
    if (bit_valid) got_b.push_back(bit_out);
    if (word_valid) begin
      got_w.push_back(word_out);
      if (first_wcyc < 0) first_wcyc = cyc;
    end
    if (track) begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        check("bit_valid_due", bit_valid, 1'b1);
        check("bit_value", bit_out, exp_q[0]);
        check("err_quiet", err, 1'b0);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end else if (bit_valid) begin
        check("bit_valid_unexpected", bit_valid, 1'b0);
      end
      if (exp_wcyc_q.size() > 0 && exp_wcyc_q[0] == cyc) begin
        check("word_valid_due", word_valid, 1'b1);
        check("word_out", word_out, exp_wq[0]);
        void'(exp_wq.pop_front());
        void'(exp_wcyc_q.pop_front());
      end else if (word_valid) begin
        check("word_valid_unexpected", word_valid, 1'b0);
      end
      if (cyc == lock_cyc - 1) check("locked_before_rise", locked, 1'b0);
      if (cyc == lock_cyc)     check("locked_rise", locked, 1'b1);
    end
    if (cyc == lat_e0 + 1) check("latency_quiet", bit_valid, 1'b0);
    if (cyc == lat_e0 + 2) begin
      check("latency_valid", bit_valid, 1'b1);
      check("latency_bit", bit_out, 1'b1);
    end
    prev_locked = locked;
    prev_bv     = bit_valid;
  end

  // ---------------- stimulus ----------------
  vec_t vecs[6];
  int   rel_first[6];

  initial begin
    int e;
    int ones;
    int good_words;
    logic [WIDTH-1:0] v;

    vecs[0] = '{8'hA5, 1'b0, 4, 8'hA5, 4};
    vecs[1] = '{8'h5A, 1'b0, 3, 8'h5A, 3};
    vecs[2] = '{8'h5A, 1'b1, 3, 8'h5A, 3};
    vecs[3] = '{8'h3C, 1'b1, 3, 8'h3C, 3};
    vecs[4] = '{8'h00, 1'b0, 3, 8'h00, 3};
    vecs[5] = '{8'hFF, 1'b1, 2, 8'hFF, 2};

    rst = 1'b0;
    din = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bit_out", bit_out, 1'b0);
    check("rst_bit_valid", bit_valid, 1'b0);
    check("rst_word_out", word_out, '0);
    check("rst_word_valid", word_valid, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_err", err, 1'b0);

    // table: a run of LOCK_BITS ones acquires lock so the payload starts a word
    for (int k = 0; k < 6; k++) begin
      reset_and_idle(vecs[k].invert, 8);
      arm(vecs[k].invert, 1'b1);
      send_preamble();
      for (int j = 0; j < vecs[k].nbytes; j++) send_byte(vecs[k].pattern);
      end_stream();
      check("tbl_word_out", word_out, vecs[k].exp_word);
      check("tbl_word_count", got_w.size(), vecs[k].exp_words);
      rel_first[k] = first_wcyc - data_start;
    end
    check("polarity_timing", rel_first[2], rel_first[1]);

    // randomized streams
    for (int r = 0; r < 5; r++) begin
      logic ri;
      ri = 1'($urandom_range(0, 1));
      reset_and_idle(ri, $urandom_range(8, 12));
      arm(ri, 1'b1);
      send_preamble();
      for (int j = 0; j < int'($urandom_range(3, 5)); j++) begin
        v = WIDTH'($urandom_range(0, 255));
        send_byte(v);
      end
      end_stream();
    end

    // wrong initial phase: a zero run shorter than the lock threshold, then ones
    reset_and_idle(1'b0, 9);
    arm(1'b0, 1'b0);
    send_bit(1'b0, e);
    send_bit(1'b0, e);
    for (int j = 0; j < 3; j++) send_byte(8'hFF);
    repeat (4) @(negedge clk);
    check("wrongphase_no_err", err_cnt, 0);
    check("wrongphase_locked", locked, 1'b1);
    check("wrongphase_bits", got_b.size(), 20);
    ones = 0;
    foreach (got_b[k]) ones += int'(got_b[k]);
    check("wrongphase_all_ones", ones, got_b.size());
    check("wrongphase_words", got_w.size(), 2);
    check("wrongphase_word_out", word_out, 8'hFF);

    // violation while locked: line frozen for 2 slots after the 4th bit of a word
    reset_and_idle(1'b0, 8);
    arm(1'b0, 1'b0);
    send_preamble();
    for (int j = 0; j < 3; j++) send_byte(8'h3C);
    v = 8'h3C;
    for (int i = WIDTH - 1; i >= 4; i--) send_bit(v[i], e);
    check("viol_locked_before", locked, 1'b1);
    check("viol_words_before", got_w.size(), 3);
    repeat (2) begin
      @(negedge clk);
      din = line ^ inv;
    end
    for (int i = 3; i >= 0; i--) send_bit(v[i], e);
    for (int j = 0; j < 4; j++) send_byte(8'h3C);
    repeat (4) @(negedge clk);
    check("viol_err_pulses", err_cnt, 1);
    check("viol_lock_drops", fall_cnt, 1);
    check("viol_relocked", locked, 1'b1);
    check("viol_word_count", got_w.size(), 7);
    good_words = 0;
    foreach (got_w[k]) if (got_w[k] == 8'h3C) good_words++;
    check("viol_words_ok", good_words, 7);

    // asynchronous reset in the middle of a word
    reset_and_idle(1'b0, 8);
    arm(1'b0, 1'b0);
    send_preamble();
    send_byte(8'h96);
    send_byte(8'h96);
    for (int i = 0; i < 3; i++) send_bit(1'b1, e);
    check("areset_pre_locked", locked, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("areset_outputs_zero", {bit_out, bit_valid, word_out, word_valid, locked, err}, '0);
    @(negedge clk);
    rst = 1'b1;
    din = 1'b0;
    repeat (8) @(negedge clk);
    arm(1'b0, 1'b1);
    send_preamble();
    for (int j = 0; j < 3; j++) send_byte(8'h96);
    end_stream();
    check("areset_words", got_w.size(), 3);
    check("areset_word_out", word_out, 8'h96);

    // latency: a lone 1 among zeros after lock
    reset_and_idle(1'b0, 8);
    arm(1'b0, 1'b1);
    send_preamble();
    send_byte(8'h00);
    v = 8'h10;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      send_bit(v[i], e);
      if (v[i]) lat_e0 = e + 1;
    end
    send_byte(8'h00);
    end_stream();
    lat_e0 = -100;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
